// File: rtl/const_pack.sv
// Shared constants and types for the TX phase-interpolator control path.
// The code width and output count are fixed here for every user of the package.
package const_pack;

  localparam int NPI            = 9;
  localparam int NOUT           = 4;
  localparam int PI_SLEW_WAIT_W = 8;

  typedef logic [NPI-1:0]            pi_code_t;
  typedef logic [NOUT-1:0][NPI-1:0]  pi_code_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SETTLE
  } pi_slew_state_t;

endpackage

// File: rtl/tx_pi_slew_ctrl_if.sv
// Target handshake plus interpolator control bundle between the requester and the slew sequencer.
interface tx_pi_slew_ctrl_if;
  import const_pack::*;

  logic         tgt_valid;
  logic         tgt_ready;
  pi_code_vec_t tgt_code;
  logic         freeze;
  pi_code_vec_t ctl_pi;
  logic         ctl_valid;
  logic         busy;
  logic         done;

  modport master (
    output tgt_valid, tgt_code, freeze,
    input  tgt_ready, ctl_pi, ctl_valid, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_code, freeze,
    output tgt_ready, ctl_pi, ctl_valid, busy, done
  );

endinterface

// File: rtl/pi_code_stepper.sv
// One channel of the slew: moves cur toward tgt along the shortest modular path,
// by at most STEP_MAX codes; a half-circle distance resolves as an increment.
module pi_code_stepper
  import const_pack::*;
#(
  parameter int unsigned STEP_MAX = 1
) (
  input  pi_code_t i_cur,
  input  pi_code_t i_tgt,
  output pi_code_t o_next,
  output logic     o_changed
);

  localparam pi_code_t STEP = pi_code_t'(STEP_MAX);
  localparam pi_code_t HALF = pi_code_t'(1 << (NPI - 1));

  pi_code_t w_up_dist;
  pi_code_t w_dn_dist;

  assign w_up_dist = i_tgt - i_cur;
  assign w_dn_dist = i_cur - i_tgt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_next    = i_cur;
    o_changed = 1'b0;
    if (w_up_dist != '0) begin
      o_changed = 1'b1;
      if (w_up_dist <= HALF) begin
        o_next = i_cur + ((w_up_dist < STEP) ? w_up_dist : STEP);
      end else begin
        o_next = i_cur - ((w_dn_dist < STEP) ? w_dn_dist : STEP);
      end
    end
  end

endmodule

// File: rtl/tx_pi_slew_ctrl.sv
// Slew sequencer for the TX interpolator codes: accepts a target set, then steps all
// channels together with a settle interval between updates until every channel lands.
module tx_pi_slew_ctrl
  import const_pack::*;
#(
  parameter int unsigned STEP_MAX = 1,
  parameter int unsigned WAIT_CYC = 4,
  parameter pi_code_t    RST_CODE = '0
) (
  input logic              clk,
  input logic              rst,
  tx_pi_slew_ctrl_if.slave bus
);

  localparam logic [PI_SLEW_WAIT_W-1:0] WAIT_LD = PI_SLEW_WAIT_W'(WAIT_CYC);

  pi_slew_state_t              r_state;
  pi_code_vec_t                r_ctl_pi;
  pi_code_vec_t                r_tgt;
  logic [PI_SLEW_WAIT_W-1:0]   r_cnt;
  logic                        r_ctl_valid;
  logic                        r_done;
  pi_code_vec_t                w_next;
  logic [NOUT-1:0]             w_changed;

  for (genvar g = 0; g < NOUT; g++) begin : g_step
    pi_code_stepper #(
      .STEP_MAX (STEP_MAX)
    ) u_step (
      .i_cur     (r_ctl_pi[g]),
      .i_tgt     (r_tgt[g]),
      .o_next    (w_next[g]),
      .o_changed (w_changed[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ctl_pi    <= {NOUT{RST_CODE}};
      r_tgt       <= {NOUT{RST_CODE}};
      r_cnt       <= '0;
      r_ctl_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_ctl_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.tgt_valid) begin
            r_tgt   <= bus.tgt_code;
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!bus.freeze) begin
            if (|w_changed) begin
              r_ctl_pi    <= w_next;
              r_ctl_valid <= 1'b1;
              r_cnt       <= WAIT_LD;
              r_state     <= SETTLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        SETTLE: begin
          // The counter holds during freeze, stretching the interval by the freeze length.
          if (!bus.freeze) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= 1) r_state <= UPDATE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tgt_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.ctl_pi    = r_ctl_pi;
  assign bus.ctl_valid = r_ctl_valid;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_tx_pi_slew_ctrl.sv
// Directed bench for tx_pi_slew_ctrl: offsets k count clock edges after the handshake
// edge (k = 0), sampled on the following falling edge.
module tb_tx_pi_slew_ctrl;
  import const_pack::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_freeze = 1'b0;
  pi_code_vec_t m_code = '0;

  always #5 clk = ~clk;

  tx_pi_slew_ctrl_if if1 ();
  tx_pi_slew_ctrl_if if8 ();

  assign if1.tgt_valid = m_valid & ~sel;
  assign if1.tgt_code  = m_code;
  assign if1.freeze    = m_freeze & ~sel;
  assign if8.tgt_valid = m_valid & sel;
  assign if8.tgt_code  = m_code;
  assign if8.freeze    = m_freeze & sel;

  tx_pi_slew_ctrl #(.STEP_MAX(1), .WAIT_CYC(4), .RST_CODE('0)) u_dut (
    .clk (clk), .rst (rst), .bus (if1)
  );

  tx_pi_slew_ctrl #(.STEP_MAX(8), .WAIT_CYC(4), .RST_CODE('0)) u_dut8 (
    .clk (clk), .rst (rst), .bus (if8)
  );

  logic         s_ready, s_busy, s_valid, s_done;
  pi_code_vec_t s_ctl;
  assign s_ready = sel ? if8.tgt_ready : if1.tgt_ready;
  assign s_busy  = sel ? if8.busy      : if1.busy;
  assign s_valid = sel ? if8.ctl_valid : if1.ctl_valid;
  assign s_done  = sel ? if8.done      : if1.done;
  assign s_ctl   = sel ? if8.ctl_pi    : if1.ctl_pi;

  int n_checks = 0;
  int n_errors = 0;

  int           pulse_k[$];
  pi_code_vec_t pulse_val[$];
  int           done_k;
  int           busy_cycles;
  int           ready_err;
  int           overlap_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic pi_code_vec_t mk(input int c0, input int c1, input int c2, input int c3);
    pi_code_vec_t v;
    v[0] = pi_code_t'(c0);
    v[1] = pi_code_t'(c1);
    v[2] = pi_code_t'(c2);
    v[3] = pi_code_t'(c3);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_valid = 1'b0; m_freeze = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers tgt, then records every ctl_valid pulse until done or the cycle budget runs out.
  task automatic run_req(input pi_code_vec_t tgt, input int fz_start, input int fz_len,
                         input bit toggle, input int budget);
    pulse_k.delete();
    pulse_val.delete();
    done_k = -1; busy_cycles = 0; ready_err = 0; overlap_err = 0;
    @(negedge clk);
    m_code  = tgt;
    m_valid = 1'b1;
    check("ready_idle", 64'(s_ready), 64'(1));
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (s_busy) busy_cycles++;
      if (s_ready == s_busy) ready_err++;
      if (s_valid && s_done) overlap_err++;
      if (s_valid) begin
        pulse_k.push_back(k);
        pulse_val.push_back(s_ctl);
      end
      if (s_done) begin
        done_k = k;
        break;
      end
      m_freeze = (k >= fz_start) && (k < fz_start + fz_len);
      if (toggle) begin
        m_valid = k[0];
        m_code  = pi_code_vec_t'({$urandom(), $urandom()});
      end else begin
        m_valid = 1'b0;
      end
    end
    m_valid  = 1'b0;
    m_freeze = 1'b0;
    check("overlap", 64'(overlap_err), 64'(0));
    check("ready_vs_busy", 64'(ready_err), 64'(0));
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_ctl", 64'(s_ctl), 64'(mk(0, 0, 0, 0)));
    check("rst_valid", 64'(s_valid), 64'(0));
    check("rst_done", 64'(s_done), 64'(0));
    check("rst_busy", 64'(s_busy), 64'(0));
    check("rst_ready", 64'(s_ready), 64'(1));

    // Three single-LSB steps on ch0, 5-cycle spacing
    run_req(mk(3, 0, 0, 0), 0, 0, 1'b0, 100);
    check("t1_npulse", 64'(pulse_k.size()), 64'(3));
    for (int i = 0; i < 3 && i < pulse_k.size(); i++) begin
      check("t1_pulse_k", 64'(pulse_k[i]), 64'(1 + 5 * i));
      check("t1_pulse_val", 64'(pulse_val[i]), 64'(mk(i + 1, 0, 0, 0)));
    end
    check("t1_done_k", 64'(done_k), 64'(16));
    check("t1_busy", 64'(busy_cycles), 64'(16));

    // Wrap-down, tie-increment, long increment
    do_reset();
    run_req(mk(510, 256, 255, 0), 0, 0, 1'b0, 1400);
    check("t2_npulse", 64'(pulse_k.size()), 64'(256));
    if (pulse_k.size() == 256) begin
      check("t2_first", 64'(pulse_val[0]), 64'(mk(511, 1, 1, 0)));
      check("t2_second", 64'(pulse_val[1]), 64'(mk(510, 2, 2, 0)));
      check("t2_255th", 64'(pulse_val[254]), 64'(mk(510, 255, 255, 0)));
      check("t2_last", 64'(pulse_val[255]), 64'(mk(510, 256, 255, 0)));
      check("t2_last_k", 64'(pulse_k[255]), 64'(1276));
    end
    check("t2_done_k", 64'(done_k), 64'(1281));
    check("t2_final", 64'(s_ctl), 64'(mk(510, 256, 255, 0)));

    // Zero-distance request
    run_req(mk(510, 256, 255, 0), 0, 0, 1'b0, 50);
    check("t3_npulse", 64'(pulse_k.size()), 64'(0));
    check("t3_done_k", 64'(done_k), 64'(1));
    check("t3_busy", 64'(busy_cycles), 64'(1));

    // Freeze for 10 cycles in SETTLE with tgt_valid toggling while busy
    do_reset();
    run_req(mk(3, 0, 0, 0), 2, 10, 1'b1, 200);
    check("t4_npulse", 64'(pulse_k.size()), 64'(3));
    if (pulse_k.size() == 3) begin
      check("t4_k0", 64'(pulse_k[0]), 64'(1));
      check("t4_k1", 64'(pulse_k[1]), 64'(16));
      check("t4_k2", 64'(pulse_k[2]), 64'(21));
    end
    check("t4_done_k", 64'(done_k), 64'(26));
    check("t4_final", 64'(s_ctl), 64'(mk(3, 0, 0, 0)));

    // Reset during SETTLE aborts, then a fresh request runs normally
    do_reset();
    @(negedge clk);
    m_code = mk(3, 0, 0, 0); m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_ctl", 64'(s_ctl), 64'(mk(1, 0, 0, 0)));
    @(negedge clk);
    check("t5_pre_busy", 64'(s_busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t5_ctl", 64'(s_ctl), 64'(mk(0, 0, 0, 0)));
    check("t5_busy", 64'(s_busy), 64'(0));
    check("t5_ready", 64'(s_ready), 64'(1));
    check("t5_done", 64'(s_done), 64'(0));
    check("t5_valid", 64'(s_valid), 64'(0));
    rst = 1'b0;
    run_req(mk(2, 0, 0, 0), 0, 0, 1'b0, 100);
    check("t5_npulse", 64'(pulse_k.size()), 64'(2));
    check("t5_done_k", 64'(done_k), 64'(11));
    check("t5_final", 64'(s_ctl), 64'(mk(2, 0, 0, 0)));

    // STEP_MAX = 8 instance
    sel = 1'b1;
    do_reset();
    run_req(mk(20, 5, 0, 0), 0, 0, 1'b0, 100);
    check("t6_npulse", 64'(pulse_k.size()), 64'(3));
    if (pulse_k.size() == 3) begin
      check("t6_v0", 64'(pulse_val[0]), 64'(mk(8, 5, 0, 0)));
      check("t6_v1", 64'(pulse_val[1]), 64'(mk(16, 5, 0, 0)));
      check("t6_v2", 64'(pulse_val[2]), 64'(mk(20, 5, 0, 0)));
    end
    check("t6_done_k", 64'(done_k), 64'(16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
